conv_result_saver: RTL and testbench

- Consumer end of the conv engine's pixel handshake.
- Accepts each convolved pixel (valid, out_pixel, addr, done), quantizes it and writes it to the per-channel output feature-map buffer.
- Returns a single-cycle save_done so the conv engine advances to the next pixel.
- Conv1 pixels are quantized directly. Conv2 pixels are accumulated across input channels in an internal 24-bit buffer, then ReLU-quantized on the last channel.

---
 rtl/conv_result_saver.sv | 206 ++++++++++++++++++++
 tb/tb_conv_result_saver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_result_saver.sv
// Conv-engine pixel consumer: quantizes conv1 pixels directly and accumulates conv2 pixels
// across input channels, writing the results to the output feature-map buffer with a save_done handshake.
module conv_result_saver #(
    parameter int unsigned MAX_PIX = 182,
    parameter int unsigned SHIFT1  = 4,
    parameter int unsigned SHIFT2  = 6,
    parameter int unsigned ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             done,
    input  logic [ACC_W-1:0] out_pixel,
    input  logic [7:0]       addr,
    input  logic [3:0]       chan,
    input  logic             layer,
    input  logic             last_chan,
    output logic             save_done,
    output logic             wr_en,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             layer_done,
    output logic             err
);

    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] MAX_ADDR = AW'(MAX_PIX);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WR, S_ACK} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] pix_q, pix_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [3:0]       chan_q, chan_d;
    logic             layer_q, layer_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             save_done_q, save_done_d;
    logic             layer_done_q, layer_done_d;
    logic             err_q, err_d;

    logic [ACC_W-1:0] acc_mem [MAX_PIX];

    logic             in_range_c;
    logic             acc_we_c;
    logic [ACC_W-1:0] acc_rd_c;
    logic [ACC_W:0]   sum_wide_c;
    logic [ACC_W-1:0] sum_sat_c;
    logic [ACC_W-1:0] q1_c;
    logic [ACC_W-1:0] q2_c;
    logic [7:0]       q1_byte_c;
    logic [7:0]       q2_byte_c;

    assign in_range_c = (addr_q < MAX_ADDR);

    // Channel 0 starts a fresh sum, so stale accumulator contents never leak in.
    assign acc_rd_c   = (in_range_c && (chan_q != 4'd0)) ? acc_mem[addr_q] : '0;
    assign sum_wide_c = {acc_rd_c[ACC_W-1], acc_rd_c} + {pix_q[ACC_W-1], pix_q};

    always_comb begin
        sum_sat_c = sum_wide_c[ACC_W-1:0];
        if (sum_wide_c[ACC_W] != sum_wide_c[ACC_W-1]) begin
            sum_sat_c = sum_wide_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Conv1: arithmetic shift then clamp to 0..255.
    assign q1_c = ACC_W'($signed(pix_q) >>> SHIFT1);
    always_comb begin
        q1_byte_c = q1_c[7:0];
        if (q1_c[ACC_W-1]) begin
            q1_byte_c = 8'd0;
        end else if (|q1_c[ACC_W-2:8]) begin
            q1_byte_c = 8'hFF;
        end
    end

    // Conv2: ReLU on the saturated sum, shift, clamp to 255.
    assign q2_c = sum_sat_c >> SHIFT2;
    always_comb begin
        q2_byte_c = q2_c[7:0];
        if (sum_sat_c[ACC_W-1]) begin
            q2_byte_c = 8'd0;
        end else if (|q2_c[ACC_W-1:8]) begin
            q2_byte_c = 8'hFF;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        addr_d       = addr_q;
        chan_d       = chan_q;
        layer_d      = layer_q;
        last_d       = last_q;
        done_d       = done_q;
        sum_d        = sum_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        save_done_d  = 1'b0;
        layer_done_d = 1'b0;
        err_d        = err_q;
        acc_we_c     = 1'b0;

        unique case (state_q)
            S_IDLE, S_ACK: begin
                state_d = S_IDLE;
                if (valid) begin
                    pix_d   = out_pixel;
                    addr_d  = addr;
                    chan_d  = chan;
                    layer_d = layer;
                    last_d  = last_chan;
                    done_d  = done;
                    state_d = S_CALC;
                    if (addr >= MAX_ADDR) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (valid) begin
                    err_d = 1'b1;
                end
                sum_d = sum_sat_c;
                if (in_range_c && !layer_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = q1_byte_c;
                end else if (in_range_c && last_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = q2_byte_c;
                end
                state_d = S_WR;
            end
            S_WR: begin
                if (valid) begin
                    err_d = 1'b1;
                end
                acc_we_c     = layer_q && in_range_c;
                save_done_d  = 1'b1;
                layer_done_d = done_q;
                state_d      = S_ACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pix_q        <= '0;
            addr_q       <= '0;
            chan_q       <= '0;
            layer_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            sum_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            save_done_q  <= 1'b0;
            layer_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            addr_q       <= addr_d;
            chan_q       <= chan_d;
            layer_q      <= layer_d;
            last_q       <= last_d;
            done_q       <= done_d;
            sum_q        <= sum_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            save_done_q  <= save_done_d;
            layer_done_q <= layer_done_d;
            err_q        <= err_d;
        end
    end

    // Accumulator RAM has no reset; channel 0 rewrites each entry.
    always_ff @(posedge clk) begin
        if (acc_we_c) begin
            acc_mem[addr_q] <= sum_q;
        end
    end

    assign save_done  = save_done_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign layer_done = layer_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_result_saver.sv
// Directed bench for conv_result_saver: vector table plus handshake, fault and reset sequences.
module tb_conv_result_saver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        done;
    logic [23:0] out_pixel;
    logic [7:0]  addr;
    logic [3:0]  chan;
    logic        layer;
    logic        last_chan;
    logic        save_done;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        layer_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    conv_result_saver dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .done       (done),
        .out_pixel  (out_pixel),
        .addr       (addr),
        .chan       (chan),
        .layer      (layer),
        .last_chan  (last_chan),
        .save_done  (save_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .layer_done (layer_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] px;
        logic [7:0]  a;
        logic [3:0]  ch;
        logic        ly;
        logic        lc;
        logic        dn;
        logic        ewen;
        logic [7:0]  edata;
    } vec_t;

    typedef struct {
        logic       w1, w2, w3;
        logic       s1, s2, s3;
        logic       l3;
        logic [7:0] wa2, wd2;
    } obs_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        done = 1'b0;
        out_pixel = '0;
        addr = '0;
        chan = '0;
        layer = 1'b0;
        last_chan = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; drives one pixel and observes the three following cycles.
    task automatic xact(input vec_t v, output obs_t o);
        valid = 1'b1;
        out_pixel = v.px;
        addr = v.a;
        chan = v.ch;
        layer = v.ly;
        last_chan = v.lc;
        done = v.dn;
        @(negedge clk);
        valid = 1'b0;
        done = 1'b0;
        o.w1 = wr_en;
        o.s1 = save_done;
        @(negedge clk);
        o.w2 = wr_en;
        o.s2 = save_done;
        o.wa2 = wr_addr;
        o.wd2 = wr_data;
        @(negedge clk);
        o.w3 = wr_en;
        o.s3 = save_done;
        o.l3 = layer_done;
    endtask

    logic       mon_en = 1'b0;
    int         sd_cnt, we_cnt, ld_cnt, ld_at;
    logic [8:0] seen;

    always @(negedge clk) begin
        if (mon_en) begin
            if (save_done) sd_cnt++;
            if (layer_done) begin
                ld_cnt++;
                ld_at = sd_cnt;
            end
            if (wr_en) begin
                we_cnt++;
                if (wr_addr < 8'd9) seen[wr_addr[3:0]] = 1'b1;
            end
        end
    end

    initial begin
        obs_t o;
        vec_t v;
        int   cnt;

        //        px           addr   ch  ly  lc  dn  wen  data
        vecs.push_back('{24'h000123, 8'd5,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12});
        vecs.push_back('{24'h010000, 8'd6,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{24'hFFFFE0, 8'd6,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{24'h000FF0, 8'd1,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{24'h001000, 8'd2,   4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{24'h00000F, 8'd3,   4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
        vecs.push_back('{24'd100,    8'd7,   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'd200,    8'd7,   4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'd340,    8'd7,   4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd10});
        vecs.push_back('{24'hFFFC18, 8'd7,   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'd10,     8'd7,   4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00});
        vecs.push_back('{24'h7FFFF0, 8'd9,   4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'h000100, 8'd9,   4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF});
        vecs.push_back('{24'h8000C1, 8'd9,   4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3});
        vecs.push_back('{24'h800000, 8'd10,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'h800000, 8'd10,  4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'h7FFFFF, 8'd10,  4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{24'h0000C1, 8'd10,  4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3});
        vecs.push_back('{24'h001000, 8'd181, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd64});

        rst_n = 1'b0;
        do_reset();
        @(negedge clk);
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_save_done", int'(save_done), 0);
        check("reset_wr_addr", int'(wr_addr), 0);
        check("reset_wr_data", int'(wr_data), 0);
        check("reset_layer_done", int'(layer_done), 0);
        check("reset_err", int'(err), 0);

        foreach (vecs[i]) begin
            xact(vecs[i], o);
            check($sformatf("v%0d_wen_t1", i), int'(o.w1), 0);
            check($sformatf("v%0d_wen_t2", i), int'(o.w2), int'(vecs[i].ewen));
            check($sformatf("v%0d_wen_t3", i), int'(o.w3), 0);
            check($sformatf("v%0d_sd_t2", i), int'(o.s2), 0);
            check($sformatf("v%0d_sd_t3", i), int'(o.s3), 1);
            check($sformatf("v%0d_ld_t3", i), int'(o.l3), int'(vecs[i].dn));
            if (vecs[i].ewen) begin
                check($sformatf("v%0d_wr_addr", i), int'(o.wa2), int'(vecs[i].a));
                check($sformatf("v%0d_wr_data", i), int'(o.wd2), int'(vecs[i].edata));
            end
        end
        @(negedge clk);
        check("table_err", int'(err), 0);

        // 3x3 conv1 map, back-to-back, done on the final pixel.
        sd_cnt = 0; we_cnt = 0; ld_cnt = 0; ld_at = -1; seen = '0;
        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            v = '{24'((i + 1) * 16), 8'(i), 4'd0, 1'b0, 1'b0, (i == 8), 1'b1, 8'(i + 1)};
            xact(v, o);
            check($sformatf("map%0d_wr_data", i), int'(o.wd2), i + 1);
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("map_save_done_cnt", sd_cnt, 9);
        check("map_wr_en_cnt", we_cnt, 9);
        check("map_addr_seen", int'(seen), 9'h1FF);
        check("map_layer_done_cnt", ld_cnt, 1);
        check("map_layer_done_at", ld_at, 9);
        check("map_err", int'(err), 0);

        // Out-of-range address.
        v = '{24'h001000, 8'd200, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        xact(v, o);
        check("oob_wen", int'(o.w2), 0);
        check("oob_save_done", int'(o.s3), 1);
        check("oob_err", int'(err), 1);
        do_reset();
        @(negedge clk);
        check("err_cleared_by_reset", int'(err), 0);

        // Repeated valid one cycle after acceptance.
        valid = 1'b1; out_pixel = 24'h000050; addr = 8'd3; chan = 4'd0; layer = 1'b0; last_chan = 1'b0;
        @(negedge clk);
        out_pixel = 24'h000070; addr = 8'd4;
        @(negedge clk);
        valid = 1'b0;
        check("dup_wen", int'(wr_en), 1);
        check("dup_wr_addr", int'(wr_addr), 3);
        check("dup_wr_data", int'(wr_data), 5);
        @(negedge clk);
        check("dup_save_done", int'(save_done), 1);
        check("dup_err", int'(err), 1);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (wr_en || save_done) cnt++;
        end
        check("dup_no_second_xact", cnt, 0);

        // Reset asserted while the write strobe is up.
        do_reset();
        @(negedge clk);
        valid = 1'b1; out_pixel = 24'h000100; addr = 8'd2; chan = 4'd0; layer = 1'b0; last_chan = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        check("rstwr_wen_before", int'(wr_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstwr_wen", int'(wr_en), 0);
        check("rstwr_wr_addr", int'(wr_addr), 0);
        check("rstwr_wr_data", int'(wr_data), 0);
        check("rstwr_save_done", int'(save_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (save_done || wr_en || layer_done) cnt++;
        end
        check("rstwr_no_save_done", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
